// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full-adder slice that the serial controller reuses every clock.
// It is built from two half-adder cells with the carries ORed together.
module serial_fa_slice (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  logic [1:0] ha_a;
  logic [1:0] ha_b;
  logic [1:0] ha_s;
  logic [1:0] ha_c;

  // Stage 0 adds the operand bits. Stage 1 folds in the incoming carry.
  assign ha_a[0] = x;
  assign ha_b[0] = y;
  assign ha_a[1] = ha_s[0];
  assign ha_b[1] = c;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ha
      assign ha_s[gi] = ha_a[gi] ^ ha_b[gi];
      assign ha_c[gi] = ha_a[gi] & ha_b[gi];
    end
  endgenerate

  assign s  = ha_s[1];
  assign co = ha_c[0] | ha_c[1];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It adds one bit per clock, LSB first, through a single
// full-adder slice, and it uses a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  // The lowest accumulator bit would be shifted out on the final step anyway,
  // so only the upper WIDTH-1 result bits are stored between steps.
  logic [WIDTH-2:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] acc_next;

  serial_fa_slice u_slice (
    .x  (opa_reg[0]),
    .y  (opb_reg[0]),
    .c  (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  assign acc_next = {slice_s, acc_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            opa_reg   <= a;
            opb_reg   <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          carry_reg <= slice_co;
          acc_reg   <= acc_next[WIDTH-1:1];
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          cnt_reg   <= cnt_reg + CW'(1);
          // The result registers are written only here, so the previous sum stays
          // readable while a new addition runs.
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= acc_next;
            cout_reg  <= slice_co;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == S_SHIFT);
  assign done = (state_reg == S_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
